// File: rtl/pulse_analyzer.sv
// pulse_analyzer: measures an incoming pulse train on one pin.
// For every pulse it reports the low interval before it (meas_delay) and its
// high interval (meas_width) in clk cycles. It also counts pulses up to a
// programmed repetition count and flags low/high intervals that run too long.
//
// Optional feature: define PULSE_ANALYZER_GLITCH_FILTER_EN to discard high
// intervals shorter than GLITCH_CYCLES. Glitch cycles are folded into the
// following delay.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   arm_in / arm_ack       capture request (sampled in IDLE) / accept strobe
//   abort_in               synchronous stop, highest priority
//   pulse_in               asynchronous pulse train
//   expected_reps          pulses to capture (0 = unlimited), latched at arm
//   timeout_cycles         max low/high interval (0 = none), latched at arm
//   meas_valid             one-cycle result strobe
//   meas_delay/meas_width  low/high cycle counts of the reported pulse
//   pulse_index            1-based index of the reported pulse
//   done                   final pulse captured (coincides with meas_valid)
//   timeout                sticky interval-timeout flag, cleared on arm_ack
//   busy_led, pulse_led    not-IDLE indicator, synchronized pulse_in level
module pulse_analyzer #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned REP_W         = 16,
  parameter int unsigned GLITCH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             arm_in,
  output logic             arm_ack,
  input  logic             abort_in,
  input  logic             pulse_in,
  input  logic [REP_W-1:0] expected_reps,
  input  logic [CNT_W-1:0] timeout_cycles,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_delay,
  output logic [CNT_W-1:0] meas_width,
  output logic [REP_W-1:0] pulse_index,
  output logic             done,
  output logic             timeout,
  output logic             busy_led,
  output logic             pulse_led
);

  localparam int unsigned AW = $clog2(SYNC_STAGES);
  localparam logic [CNT_W-1:0] GLITCH_MIN = CNT_W'(GLITCH_CYCLES);
`ifdef PULSE_ANALYZER_GLITCH_FILTER_EN
  localparam bit GLITCH_EN = 1'b1;
`else
  localparam bit GLITCH_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    WAIT_HIGH,
    SKIP,
    MEAS_HIGH
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [AW-1:0]          align_q, align_d;
  logic [CNT_W-1:0]       low_q, low_d;
  logic [CNT_W-1:0]       hi_q, hi_d;
  logic [CNT_W-1:0]       dly_q, dly_d;
  logic [REP_W-1:0]       count_q, count_d;
  logic [REP_W-1:0]       reps_q, reps_d;
  logic [CNT_W-1:0]       tmo_q, tmo_d;
  logic                   valid_q, valid_d;
  logic [CNT_W-1:0]       mdelay_q, mdelay_d;
  logic [CNT_W-1:0]       mwidth_q, mwidth_d;
  logic [REP_W-1:0]       index_q, index_d;
  logic                   done_q, done_d;
  logic                   timeout_q, timeout_d;

  logic             level;
  logic             rise;
  logic             fall;
  logic             tmo_on;
  logic             glitch;
  logic [REP_W-1:0] next_count;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign level      = sync_q[SYNC_STAGES-1];
  assign rise       = level & ~prev_q;
  assign fall       = ~level & prev_q;
  assign tmo_on     = (tmo_q != '0);
  assign glitch     = GLITCH_EN && (hi_q < GLITCH_MIN);
  assign next_count = count_q + REP_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      prev_q <= level;
    end
  end

  // Counter timing: in WAIT_HIGH the low counter holds (low cycles seen - 1)
  // for the current cycle, so the value at the rising-edge cycle equals the
  // delay. Likewise the high counter equals the width at the falling-edge
  // cycle. The fall cycle itself is the first low cycle of the next delay.
  always_comb begin
    state_d   = state_q;
    align_d   = align_q;
    low_d     = low_q;
    hi_d      = hi_q;
    dly_d     = dly_q;
    count_d   = count_q;
    reps_d    = reps_q;
    tmo_d     = tmo_q;
    valid_d   = 1'b0;
    mdelay_d  = mdelay_q;
    mwidth_d  = mwidth_q;
    index_d   = index_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    arm_ack   = 1'b0;

    if (abort_in) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (arm_in) begin
            arm_ack   = 1'b1;
            timeout_d = 1'b0;
            reps_d    = expected_reps;
            tmo_d     = timeout_cycles;
            count_d   = '0;
            align_d   = '0;
            state_d   = ALIGN;
          end
        end
        ALIGN: begin
          if (align_q == AW'(SYNC_STAGES - 1)) begin
            low_d   = '0;
            state_d = WAIT_HIGH;
          end else begin
            align_d = align_q + AW'(1);
          end
        end
        WAIT_HIGH: begin
          if (tmo_on && (low_q >= tmo_q)) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
          end else if (rise) begin
            dly_d   = low_q;
            hi_d    = CNT_W'(1);
            low_d   = sat_inc(low_q);
            state_d = MEAS_HIGH;
          end else if (level) begin
            // Already high right after alignment: drop the partial pulse.
            hi_d    = '0;
            state_d = SKIP;
          end else begin
            low_d = sat_inc(low_q);
          end
        end
        SKIP: begin
          if (tmo_on && (hi_q >= tmo_q)) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
          end else if (fall) begin
            low_d   = CNT_W'(1);
            state_d = WAIT_HIGH;
          end else begin
            hi_d = sat_inc(hi_q);
          end
        end
        MEAS_HIGH: begin
          // Low counter keeps running so a discarded glitch adds to the delay.
          low_d = sat_inc(low_q);
          if (tmo_on && (hi_q >= tmo_q)) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
          end else if (fall) begin
            state_d = WAIT_HIGH;
            if (!glitch) begin
              low_d    = CNT_W'(1);
              valid_d  = 1'b1;
              mdelay_d = dly_q;
              mwidth_d = hi_q;
              index_d  = next_count;
              count_d  = next_count;
              if ((reps_q != '0) && (next_count == reps_q)) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end
            end
          end else begin
            hi_d = sat_inc(hi_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      align_q   <= '0;
      low_q     <= '0;
      hi_q      <= '0;
      dly_q     <= '0;
      count_q   <= '0;
      reps_q    <= '0;
      tmo_q     <= '0;
      valid_q   <= 1'b0;
      mdelay_q  <= '0;
      mwidth_q  <= '0;
      index_q   <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      align_q   <= align_d;
      low_q     <= low_d;
      hi_q      <= hi_d;
      dly_q     <= dly_d;
      count_q   <= count_d;
      reps_q    <= reps_d;
      tmo_q     <= tmo_d;
      valid_q   <= valid_d;
      mdelay_q  <= mdelay_d;
      mwidth_q  <= mwidth_d;
      index_q   <= index_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign meas_valid  = valid_q;
  assign meas_delay  = mdelay_q;
  assign meas_width  = mwidth_q;
  assign pulse_index = index_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign busy_led    = (state_q != IDLE);
  assign pulse_led   = level;

endmodule

// File: tb/tb_pulse_analyzer.sv
// Scoreboard bench for pulse_analyzer: a waveform is described as runs of
// low/high cycles, a run-length reference model predicts the strobes, and a
// monitor compares every meas_valid against the predicted queue.
module tb_pulse_analyzer;

  localparam int S  = 2;
  localparam int CW = 32;
  localparam int RW = 16;
  localparam int GC = 2;
`ifdef PULSE_ANALYZER_GLITCH_FILTER_EN
  localparam bit GLITCH = 1'b1;
`else
  localparam bit GLITCH = 1'b0;
`endif

  localparam int END_NONE = 0;
  localparam int END_DONE = 1;
  localparam int END_TO   = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          arm_in = 1'b0;
  logic          abort_in = 1'b0;
  logic          pulse_in = 1'b0;
  logic [RW-1:0] expected_reps = '0;
  logic [CW-1:0] timeout_cycles = '0;
  logic          arm_ack;
  logic          meas_valid;
  logic [CW-1:0] meas_delay;
  logic [CW-1:0] meas_width;
  logic [RW-1:0] pulse_index;
  logic          done;
  logic          timeout;
  logic          busy_led;
  logic          pulse_led;

  pulse_analyzer #(
    .SYNC_STAGES  (S),
    .CNT_W        (CW),
    .REP_W        (RW),
    .GLITCH_CYCLES(GC)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .arm_in        (arm_in),
    .arm_ack       (arm_ack),
    .abort_in      (abort_in),
    .pulse_in      (pulse_in),
    .expected_reps (expected_reps),
    .timeout_cycles(timeout_cycles),
    .meas_valid    (meas_valid),
    .meas_delay    (meas_delay),
    .meas_width    (meas_width),
    .pulse_index   (pulse_index),
    .done          (done),
    .timeout       (timeout),
    .busy_led      (busy_led),
    .pulse_led     (pulse_led)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint dly;
    longint wid;
    longint idx;
    longint dn;
  } exp_t;

  exp_t expq[$];
  int   lows[$];
  int   highs[$];
  int   checks = 0;
  int   errors = 0;
  bit   arm_window = 1'b0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference model on run lengths: each (low, high) pair is one candidate
  // pulse; an interval of T or more cycles times out; short highs are glitches
  // when filtering is enabled and their cycles join the next delay.
  function automatic int model(input int reps, input int tmo);
    longint acc = 0;
    int     cnt = 0;
    exp_t   e;
    for (int p = 0; p < lows.size(); p++) begin
      acc += lows[p];
      if (tmo != 0 && acc >= tmo) return END_TO;
      if (tmo != 0 && highs[p] >= tmo) return END_TO;
      if (GLITCH && highs[p] < GC) begin
        acc += highs[p];
      end else begin
        cnt++;
        e.dly = acc;
        e.wid = highs[p];
        e.idx = cnt % (1 << RW);
        e.dn  = (reps != 0 && cnt == reps) ? 1 : 0;
        expq.push_back(e);
        acc = 0;
        if (e.dn != 0) return END_DONE;
      end
    end
    return (tmo != 0) ? END_TO : END_NONE;
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (arm_ack && !arm_window) begin
        errors++;
        $display("FAIL unexpected_arm_ack actual=1 required=0");
      end
      if (done && !meas_valid) begin
        errors++;
        $display("FAIL done_without_strobe actual=1 required=0");
      end
      if (meas_valid) begin
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe actual=delay %0d width %0d index %0d required=no strobe",
                   meas_delay, meas_width, pulse_index);
        end else begin
          exp_t e;
          e = expq.pop_front();
          check("meas_delay", longint'(meas_delay), e.dly);
          check("meas_width", longint'(meas_width), e.wid);
          check("pulse_index", longint'(pulse_index), e.idx);
          check("done_with_strobe", longint'(done), e.dn);
        end
      end
    end
  end

  // Arms with the given configuration, plays the waveform (skip leading high
  // cycles, then lows/highs pairs, then low), and checks the capture's end.
  task automatic run_capture(input int skip, input int reps, input int tmo, input bit toggle_arm);
    bit wav[$];
    int endt;
    int waited;
    endt = model(reps, tmo);
    for (int i = 0; i < skip; i++) wav.push_back(1'b1);
    for (int p = 0; p < lows.size(); p++) begin
      for (int i = 0; i < lows[p]; i++) wav.push_back(1'b0);
      for (int i = 0; i < highs[p]; i++) wav.push_back(1'b1);
    end
    for (int i = 0; i < S + 6; i++) wav.push_back(1'b0);

    @(negedge clk);
    arm_window     = 1'b1;
    arm_in         = 1'b1;
    abort_in       = 1'b0;
    expected_reps  = RW'(reps);
    timeout_cycles = CW'(tmo);
    pulse_in       = (skip > 0);
    #1;
    check("arm_ack", longint'(arm_ack), 1);

    for (int c = 0; c < wav.size(); c++) begin
      @(negedge clk);
      pulse_in = wav[c];
      if (c == 0) begin
        arm_in         = 1'b0;
        arm_window     = 1'b0;
        // Changes after arm_ack must not affect the running capture.
        expected_reps  = RW'($urandom_range(1, 3));
        timeout_cycles = CW'($urandom_range(1, 3));
        check("timeout_cleared_on_arm", longint'(timeout), 0);
        check("busy_after_arm", longint'(busy_led), 1);
      end else if (toggle_arm) begin
        arm_in = (c >= 2 && c <= 12) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    arm_in = 1'b0;

    if (endt == END_NONE) begin
      @(negedge clk);
      abort_in = 1'b1;
      @(negedge clk);
      abort_in = 1'b0;
      check("busy_after_abort", longint'(busy_led), 0);
    end else begin
      waited = 0;
      while (busy_led && waited < tmo + 200) begin
        @(negedge clk);
        waited++;
      end
      check("busy_at_end", longint'(busy_led), 0);
    end
    check("timeout_flag", longint'(timeout), (endt == END_TO) ? 1 : 0);
    repeat (S + 3) @(negedge clk);
    check("strobes_outstanding", longint'(expq.size()), 0);
    expq.delete();
  endtask

  task automatic set_pairs(input int n, input int lo, input int hi);
    lows.delete();
    highs.delete();
    for (int i = 0; i < n; i++) begin
      lows.push_back(lo);
      highs.push_back(hi);
    end
  endtask

  initial begin
    int reps, tmo, skip, np;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_meas_valid", longint'(meas_valid), 0);
    check("rst_meas_delay", longint'(meas_delay), 0);
    check("rst_meas_width", longint'(meas_width), 0);
    check("rst_pulse_index", longint'(pulse_index), 0);
    check("rst_done", longint'(done), 0);
    check("rst_timeout", longint'(timeout), 0);
    check("rst_busy_led", longint'(busy_led), 0);
    check("rst_pulse_led", longint'(pulse_led), 0);
    check("rst_arm_ack", longint'(arm_ack), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two pulses low 10 / high 20
    set_pairs(2, 10, 20);
    run_capture(0, 2, 0, 1'b0);

    // Generator loopback pattern: delay 10, width 20, three repetitions
    set_pairs(3, 10, 20);
    run_capture(0, 3, 0, 1'b0);

    // Unlimited mode, 50 pulses, then abort
    set_pairs(50, 5, 3);
    run_capture(0, 0, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      repeat (4) @(negedge clk) pulse_in = 1'b1;
      repeat (4) @(negedge clk) pulse_in = 1'b0;
    end
    check("busy_idle_after_abort", longint'(busy_led), 0);

    // Timeout on a held-low input; next arm clears it
    lows.delete();
    highs.delete();
    run_capture(0, 1, 100, 1'b0);

    // Armed while high: partial pulse skipped; arm_in toggled mid-capture
    lows.delete();
    highs.delete();
    lows.push_back(4);
    highs.push_back(6);
    run_capture(7, 1, 0, 1'b1);

    // Short pulse followed by a longer one (glitch filter dependent)
    lows.delete();
    highs.delete();
    lows.push_back(5);
    highs.push_back(1);
    lows.push_back(4);
    highs.push_back(3);
    run_capture(0, 2, 0, 1'b0);

    // abort_in together with arm_in in IDLE suppresses arm_ack
    @(negedge clk);
    arm_in   = 1'b1;
    abort_in = 1'b1;
    #1;
    check("arm_ack_with_abort", longint'(arm_ack), 0);
    @(negedge clk);
    check("busy_after_abort_arm", longint'(busy_led), 0);
    arm_in   = 1'b0;
    abort_in = 1'b0;

    // Reset asserted during MEAS_HIGH
    @(negedge clk);
    arm_window     = 1'b1;
    arm_in         = 1'b1;
    expected_reps  = RW'(1);
    timeout_cycles = '0;
    pulse_in       = 1'b0;
    @(negedge clk);
    arm_in     = 1'b0;
    arm_window = 1'b0;
    repeat (5) @(negedge clk);
    pulse_in = 1'b1;
    repeat (8) @(negedge clk);
    check("busy_before_reset", longint'(busy_led), 1);
    reset_n = 1'b0;
    #1;
    check("midrst_meas_valid", longint'(meas_valid), 0);
    check("midrst_done", longint'(done), 0);
    check("midrst_busy_led", longint'(busy_led), 0);
    check("midrst_pulse_led", longint'(pulse_led), 0);
    check("midrst_meas_width", longint'(meas_width), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (S + 2) @(negedge clk);
    check("pulse_led_level", longint'(pulse_led), 1);
    pulse_in = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_after_reset", longint'(busy_led), 0);

    // Randomized captures
    for (int t = 0; t < 40; t++) begin
      reps = $urandom_range(0, 4);
      tmo  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(4, 30);
      skip = (tmo == 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
      np   = $urandom_range(1, 5);
      lows.delete();
      highs.delete();
      for (int i = 0; i < np; i++) begin
        lows.push_back($urandom_range(1, 12));
        highs.push_back(($urandom_range(0, 4) == 0) ? 1 : $urandom_range(1, 14));
      end
      run_capture(skip, reps, tmo, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    errors++;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
